// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants so the sync generator and every renderer
// agree on the active-area bounds and sync polarity.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W    = 10;

    localparam logic SYNC_POL = 1'b0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic in_range(logic [CNT_W-1:0] c, logic [CNT_W-1:0] lo,
                                      logic [CNT_W-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on en, decodes the sync window and the
// visible region of the current count.
module vga_axis_counter import vga_pkg::*; #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             active
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] ACT     = CNT_W'(ACTIVE);

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + CNT_W'(1);
    end

    // wrap is a level; the caller qualifies it with its own enable
    assign wrap   = (count == LAST);
    assign sync   = in_range(count, SYNC_LO, SYNC_HI);
    assign active = (count < ACT);
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, H/V counters and a
// registered pin stage that lags the coordinates by one pixel period.
module vga_sync_gen #(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk
);
    import vga_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt, div_next;
    logic             h_wrap, h_sync, h_act;
    logic             v_wrap, v_sync, v_act;
    rgb_t             pix_q;

    assign pixel_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign div_next   = pixel_tick ? '0 : div_cnt + DIV_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_next;
            // registered from div_next so the pin is high exactly while div_cnt >= CLK_DIV/2
            vga_clk <= (div_next >= DIV_W'(CLK_DIV / 2));
        end
    end

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clock(clock), .reset(reset), .en(pixel_tick),
        .count(pixel_x), .wrap(h_wrap), .sync(h_sync), .active(h_act)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clock(clock), .reset(reset), .en(pixel_tick & h_wrap),
        .count(pixel_y), .wrap(v_wrap), .sync(v_sync), .active(v_act)
    );

    assign video_on = h_act & v_act;

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q       <= '0;
            vga_blank_n <= 1'b0;
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_tick & h_wrap & v_wrap;
            if (pixel_tick) begin
                pix_q       <= video_on ? rgb_t'{red_in, green_in, blue_in} : '0;
                vga_blank_n <= video_on;
                vga_hsync   <= h_sync ? SYNC_POL : ~SYNC_POL;
                vga_vsync   <= v_sync ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign vga_r      = pix_q.r;
    assign vga_g      = pix_q.g;
    assign vga_b      = pix_q.b;
    assign vga_sync_n = 1'b0;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance plus a shrunk-raster
// instance (full frames in a few hundred clocks), both against an arithmetic model.
module tb_vga_sync_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       tick;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       sync_n;
        logic       vclk;
    } obs_t;

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       hs;
        logic       bl;
        logic [7:0] r;
    } vec_t;

    // shrunk raster: H 8+2+3+2 = 15, V 6+2+2+3 = 13, 3 clocks/pixel, active-high syncs
    localparam int SD = 3;
    localparam int S_FRAME_CLK = 15 * 13 * SD;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst0, rst1;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic [9:0] px0, py0, px1, py1;
    logic       von0, tick0, fs0, hs0, vs0, bl0, sn0, vc0;
    logic       von1, tick1, fs1, hs1, vs1, bl1, sn1, vc1;
    logic [7:0] vr0, vg0, vb0, vr1, vg1, vb1;
    obs_t       obs0, obs1;

    vga_sync_gen dut0 (
        .clock(clock), .reset(rst0), .pixel_x(px0), .pixel_y(py0), .video_on(von0),
        .pixel_tick(tick0), .frame_start(fs0), .red_in(r0), .green_in(g0), .blue_in(b0),
        .vga_r(vr0), .vga_g(vg0), .vga_b(vb0), .vga_hsync(hs0), .vga_vsync(vs0),
        .vga_blank_n(bl0), .vga_sync_n(sn0), .vga_clk(vc0)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(SD), .SYNC_POL(1'b1)
    ) dut1 (
        .clock(clock), .reset(rst1), .pixel_x(px1), .pixel_y(py1), .video_on(von1),
        .pixel_tick(tick1), .frame_start(fs1), .red_in(r1), .green_in(g1), .blue_in(b1),
        .vga_r(vr1), .vga_g(vg1), .vga_b(vb1), .vga_hsync(hs1), .vga_vsync(vs1),
        .vga_blank_n(bl1), .vga_sync_n(sn1), .vga_clk(vc1)
    );

    assign obs0 = {px0, py0, von0, tick0, fs0, vr0, vg0, vb0, hs0, vs0, bl0, sn0, vc0};
    assign obs1 = {px1, py1, von1, tick1, fs1, vr1, vg1, vb1, hs1, vs1, bl1, sn1, vc1};

    int vectors = 0, miscompares = 0;
    int cyc = 0, n0 = 0, n1 = 0, seed;
    int last_fs1 = -1, vs_cnt1 = 0;
    vec_t tbl[15];

    // renderer colour for pixel index p: mode 0 = {x[7:0], AA, 55}, mode 1 = hash
    function automatic logic [23:0] colour(int p, int ht, int mode, int sd);
        int x;
        logic [31:0] h;
        if (mode == 0) begin
            x = p % ht;
            return {x[7:0], 8'hAA, 8'h55};
        end
        h = (32'(p) * 32'h9E3779B1) ^ 32'(sd);
        h = h ^ (h >> 13);
        return h[23:0];
    endfunction

    // expected observables n clocks after reset release, from raster arithmetic
    function automatic obs_t model(int n, int d, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, logic pol,
                                   int mode, int sd);
        int ht, vt, t, ph, x, y, p, qx, qy;
        logic on;
        obs_t o;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        t  = n / d;
        ph = n % d;
        x  = t % ht;
        y  = (t / ht) % vt;
        o.x      = 10'(x);
        o.y      = 10'(y);
        o.von    = (x < ha) && (y < va);
        o.tick   = (ph == d - 1);
        o.fs     = (n > 0) && (ph == 0) && (t % (ht * vt) == 0);
        o.sync_n = 1'b0;
        o.vclk   = (ph >= d / 2);
        if (t == 0) begin
            {o.r, o.g, o.b} = 24'h0;
            o.blank = 1'b0;
            o.hs    = ~pol;
            o.vs    = ~pol;
        end else begin
            p  = t - 1;
            qx = p % ht;
            qy = (p / ht) % vt;
            on = (qx < ha) && (qy < va);
            {o.r, o.g, o.b} = on ? colour(p, ht, mode, sd) : 24'h0;
            o.blank = on;
            o.hs = (qx >= ha + hf && qx < ha + hf + hs) ? pol : ~pol;
            o.vs = (qy >= va + vf && qy < va + vf + vs) ? pol : ~pol;
        end
        return o;
    endfunction

    task automatic check(string name, obs_t got, obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        obs_t e0, e1;
        @(posedge clock);
        cyc++;
        n0 = rst0 ? 0 : n0 + 1;
        n1 = rst1 ? 0 : n1 + 1;
        #1;
        e0 = model(n0, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 0, seed);
        e1 = model(n1, SD, 8, 2, 3, 2, 6, 2, 2, 3, 1'b1, 1, seed);
        check("dut0_pins", obs0, e0);
        check("dut1_pins", obs1, e1);
        if (rst1) begin
            last_fs1 = -1;
            vs_cnt1  = 0;
        end else if (fs1) begin
            if (last_fs1 >= 0) begin
                chk_int("frame_interval", cyc - last_fs1, S_FRAME_CLK);
                chk_int("vsync_clocks", vs_cnt1, 2 * 15 * SD);
            end
            last_fs1 = cyc;
            vs_cnt1  = 0;
        end
        if (!rst1 && vs1) vs_cnt1++;
        // only the value present on the tick clock is meaningful; others are noise
        {r0, g0, b0} = (n0 % 2 == 1) ? colour(n0 / 2, 800, 0, seed) : 24'($urandom);
        {r1, g1, b1} = (n1 % SD == SD - 1) ? colour(n1 / SD, 15, 1, seed) : 24'($urandom);
    endtask

    initial begin
        int hcnt, fcnt;
        seed = int'($urandom);
        tbl[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{2,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[3]  = '{3,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 8'h00};
        tbl[4]  = '{10,   10'd5,   10'd0, 1'b0, 1'b1, 1'b1, 8'h04};
        tbl[5]  = '{12,   10'd6,   10'd0, 1'b0, 1'b1, 1'b1, 8'h05};
        tbl[6]  = '{1280, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 8'h7F};
        tbl[7]  = '{1282, 10'd641, 10'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1313, 10'd656, 10'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{1314, 10'd657, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1504, 10'd752, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{1506, 10'd753, 10'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[12] = '{1599, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[13] = '{1600, 10'd0,   10'd1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[14] = '{1602, 10'd1,   10'd1, 1'b0, 1'b1, 1'b1, 8'h00};

        rst0 = 1'b1;
        rst1 = 1'b1;
        {r0, g0, b0, r1, g1, b1} = '0;
        repeat (5) step();
        rst0 = 1'b0;
        rst1 = 1'b0;

        // directed checkpoints on the full-size raster
        foreach (tbl[i]) begin
            while (n0 < tbl[i].n) step();
            check("table", {px0, py0, tick0, hs0, bl0, vr0, 23'h0, 8'h0, 4'h0},
                           {tbl[i].x, tbl[i].y, tbl[i].tick, tbl[i].hs, tbl[i].bl,
                            tbl[i].r, 23'h0, 8'h0, 4'h0});
        end

        hcnt = 0;
        while (n0 < 3200) begin
            step();
            if (hs0 == 1'b0) hcnt++;
        end
        chk_int("hsync_low_clocks", hcnt, 192);

        // reset mid-frame at (700,2)
        while (n0 < 2 * (2 * 800 + 700)) step();
        chk_int("pre_reset_x", int'(px0), 700);
        chk_int("pre_reset_y", int'(py0), 2);
        rst0 = 1'b1;
        step();
        chk_int("reset_state", int'({px0, py0, hs0, vs0, bl0, vc0, fs0, vr0}),
                int'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        rst0 = 1'b0;
        fcnt = 0;
        repeat (2000) begin
            step();
            if (fs0) fcnt++;
        end
        chk_int("no_fs_after_reset", fcnt, 0);

        // reset the shrunk raster at a random point, then let it run two frames
        repeat ($urandom_range(1, 200)) step();
        rst1 = 1'b1;
        repeat (3) step();
        rst1 = 1'b0;
        repeat (2 * S_FRAME_CLK + 300) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock and drives the DAC/connector pins. Produces the `pixel_x`/`pixel_y` coordinates consumed by every screen renderer: the game-over screen, playfield, paddle, ball and bricks. Takes back the renderer's RGB for that coordinate, blanks it outside the active area, and emits it aligned with `hsync`/`vsync`. It is the counterpart of the pixel-coordinate → RGB interface the renderers implement.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, system clocks per pixel; must be ≥2
- `SYNC_POL`, 0, asserted sync level (0 = active-low)
- `clock`  in  1  system clock; reset `reset`, synchronous, active-high; clock `clock`
- `reset`  in  1  synchronous active-high reset
- `pixel_x`  out  10  current horizontal count, 0..H_TOTAL-1
- `pixel_y`  out  10  current vertical count, 0..V_TOTAL-1
- `video_on`  out  1  `pixel_x` < H_ACTIVE and `pixel_y` < V_ACTIVE
- `pixel_tick`  out  1  one-clock pulse on the last clock of each pixel period
- `frame_start`  out  1  one-clock pulse on the first clock of (0,0) after a frame wrap
- `red_in`, `green_in`, `blue_in`  in  8 each  renderer colour for the current `pixel_x`/`pixel_y`
- `vga_r`, `vga_g`, `vga_b`  out  8 each  registered DAC colour
- `vga_hsync`, `vga_vsync`  out  1  registered syncs
- `vga_blank_n`  out  1  registered, 1 during active video
- `vga_sync_n`  out  1  constant 0
- `vga_clk`  out  1  registered DAC pixel clock

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525). Counters are 10-bit unsigned.
- `div_cnt` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (`div_cnt` == CLK_DIV-1).
- On `pixel_tick`, `h_cnt` increments. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments. At `v_cnt` = V_TOTAL-1 with `h_cnt` wrapping, `v_cnt` wraps to 0.
- `pixel_x`/`pixel_y` are the counters directly. They stay stable for CLK_DIV clocks.
- hsync is asserted for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- vsync is asserted for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
- Output stage updates only on `pixel_tick` clocks. It captures `*_in` if `video_on` is 1, else 0. It also captures `video_on` into `vga_blank_n` and the hsync/vsync decode of the current counters.
- Renderers may therefore take up to CLK_DIV-1 clocks of latency.
- `vga_clk` is high exactly while `div_cnt` ≥ CLK_DIV/2, registered. Its rising edge falls mid-period of the registered output pixel.

## Timing
- Reset values: `div_cnt`=0, `h_cnt`=0, `v_cnt`=0, `vga_r/g/b`=0, `vga_blank_n`=0, `vga_hsync`=`vga_vsync`=~SYNC_POL (1 by default), `vga_clk`=0, `pixel_tick`=0, `frame_start`=0.
- Reset asserted mid-frame returns all of the above on the next edge. Counting resumes from (0,0) on the first clock after release.
- `frame_start` does not fire on reset release, only on wrap.
- Output latency: pin outputs lag `pixel_x`/`pixel_y` by exactly one pixel period (CLK_DIV clocks). RGB, blank and syncs are mutually aligned.
- The pixel (639,y) is the last one shown. Pixel (640,y) outputs RGB 0 and `vga_blank_n`=0, regardless of `*_in`.
- Line period is 800 ticks. Frame period is 420 000 ticks = 840 000 clocks at CLK_DIV=2.

## Structure
- Shared package `vga_pkg`: the default 640x480 timing constants, derived H_TOTAL/V_TOTAL, and the sync polarity constant, so renderers use the same active-area bounds.
- Sub-module `vga_axis_counter` (parameters ACTIVE/FP/SYNC/BP; inputs `clock`, `reset`, `en`; outputs `count`, `wrap`, `sync`, `active`). It is instantiated twice:
  - H instance: `en` = `pixel_tick`.
  - V instance: `en` = `pixel_tick` & H `wrap`.

## Test plan
- Reset held 5 clocks, then released → `pixel_x`=0, `pixel_y`=0, `vga_hsync`=1, `vga_blank_n`=0. `pixel_tick` first pulses on clock 2 after release, and `pixel_x`=1 on clock 3.
- Run one line → `vga_hsync` low for exactly 96 ticks (192 clocks), beginning one pixel period after `pixel_x`=656. `pixel_y` increments when `pixel_x` wraps 799→0.
- Run one full frame → `vga_vsync` low for 2 lines (1600 ticks) starting at `pixel_y`=490. `frame_start` pulses once, 840 000 clocks after the previous pulse.
- Drive `red_in`=`pixel_x`[7:0], `green_in`=8'hAA, `blue_in`=8'h55 → output for x=5 shows `vga_r`=8'h05, one pixel period late. Over x=640..799 and y=480..524, `vga_r/g/b`=0 and `vga_blank_n`=0.
- Assert reset at (`pixel_x`,`pixel_y`)=(700,300) → next clock shows all reset values. After release, counting restarts at (0,0) and no `frame_start` occurs until the next wrap.
- Check `vga_clk` over 10 ticks → a 2-clock-period square wave, high on `div_cnt`=1. `vga_sync_n` remains 0 throughout.
